mmu_bus_arbiter: RTL and testbench
==================================

MMU_BUS_ARBITER -- requirements
Module: mmu_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width of all ports.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width of all ports.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rstb, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports i_req (input, 1), i_addr (input, ADDR_W), i_gnt (output, 1), i_rvalid (output, 1) and i_rdata (output, DATA_W), forming requester 0 (instruction fetch, read-only).
REQ-006 SHALL have ports d_req (input, 1), d_addr (input, ADDR_W), d_wr_ena (input, 1), d_wr_data (input, DATA_W), d_gnt (output, 1), d_rvalid (output, 1) and d_rdata (output, DATA_W), forming requester 1 (load/store).
REQ-007 SHALL have ports mem_addr (output, ADDR_W), mem_wr_ena (output, 1), mem_wr_data (output, DATA_W) and mem_rd_data (input, DATA_W), forming the single MMU port; read data returns 1 cycle after the address is presented.
REQ-008 SHALL have port mem_busy, input, 1: while high, the MMU accepts no new access.

Function
REQ-009 SHALL combinationally grant at most one requester per cycle; a grant is i_gnt or d_gnt high.
REQ-010 SHALL issue a grant only when that requester's req is high and mem_busy is low.
REQ-011 SHALL, in the grant cycle, drive mem_addr/mem_wr_ena/mem_wr_data from the granted port; i_addr SHALL drive mem_wr_ena=0 and mem_wr_data=0.
REQ-012 SHALL, when no grant is issued, hold mem_wr_ena=0 and hold mem_addr at its last granted value.
REQ-013 SHALL treat a request as accepted on the rising edge where req and gnt are both high; requesters hold req/addr/data stable until then.
REQ-014 SHALL register the owner and read/write type of each accepted access in a 1-deep pipeline (states NONE, RD_I, RD_D, WR_D).
REQ-015 SHALL assert exactly one of i_rvalid/d_rvalid for exactly 1 cycle, the cycle after an accepted read, with rdata = mem_rd_data; rdata SHALL be 0 when rvalid is low.
REQ-016 SHALL NOT assert rvalid for an accepted write; d_gnt completes a write.
REQ-017 SHALL support back-to-back grants every cycle: the grant for access N+1 SHALL coincide with rvalid for access N.
REQ-018 SHALL, when both req are high, select by the policy in REQ-026/027; when only one req is high, grant it regardless of history.
REQ-019 SHALL, when mem_busy rises in the cycle after a grant, still deliver that access's rvalid; only new grants stall.
REQ-020 SHALL drop a request withdrawn before grant without side effects.

Reset
REQ-021 SHALL, while rstb is low, force i_gnt=d_gnt=0, i_rvalid=d_rvalid=0, i_rdata=d_rdata=0, mem_wr_ena=0, mem_addr=0, mem_wr_data=0.
REQ-022 SHALL discard a pending response on reset mid-access; no rvalid is produced after release for pre-reset accesses.
REQ-023 SHALL reset the round-robin pointer so requester 1 (data) has priority first.
REQ-024 SHALL permit grants from the first rising edge with rstb high.

Configuration
REQ-025 SHALL use macro MMU_ARB_ROUND_ROBIN_EN.
REQ-026 SHALL, with MMU_ARB_ROUND_ROBIN_EN defined, alternate priority on contention: the requester last granted gets lowest priority next cycle.
REQ-027 SHALL, without the macro, use fixed priority with d_req always winning; no pointer register exists.

Verification
REQ-028 SHALL cover: single i_req read at addr 0x100 with mem returning 0xDEADBEEF -> i_gnt in cycle 0, i_rvalid and i_rdata=0xDEADBEEF in cycle 1, d_rvalid stays 0.
REQ-029 SHALL cover: d_req write addr 0x200, data 0x12345678 -> d_gnt for 1 cycle, mem_wr_ena=1 with those values, no d_rvalid.
REQ-030 SHALL cover: both req held for 6 cycles with ROUND_ROBIN_EN -> grants D,I,D,I,D,I; without the macro -> D in all 6 cycles, i_gnt never high.
REQ-031 SHALL cover: mem_busy high for cycles 2-4 during a continuous i_req stream -> no grants in cycles 2-4, rvalid in cycle 2 for the grant of cycle 1, grants resume in cycle 5.
REQ-032 SHALL cover: rstb pulled low in the cycle after a d read grant -> d_rvalid never asserts and all outputs read 0 during reset.

Source files
------------

// File: rtl/mmu_bus_arbiter.sv
// Two-requester (ifetch / load-store) arbiter onto a single MMU port with a 1-deep response pipeline.
// Optional MMU_ARB_ROUND_ROBIN_EN: alternating priority on contention; otherwise data port always wins.
module mmu_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstb,
    // requester 0: instruction fetch, read-only
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    // requester 1: load/store
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_wr_ena,
    input  logic [DATA_W-1:0] d_wr_data,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    // MMU port
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_ena,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_busy
);

    typedef enum logic [1:0] {
        ST_NONE = 2'd0,
        ST_RD_I = 2'd1,
        ST_RD_D = 2'd2,
        ST_WR_D = 2'd3
    } pipe_st_e;

    pipe_st_e          state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              d_wins;
    logic              gnt_i, gnt_d;

    // Grants are gated by rstb so nothing leaves the block while reset is held.
    assign gnt_d = rstb & ~mem_busy & d_req & d_wins;
    assign gnt_i = rstb & ~mem_busy & i_req & ~gnt_d;
    assign i_gnt = gnt_i;
    assign d_gnt = gnt_d;

`ifdef MMU_ARB_ROUND_ROBIN_EN
    logic d_prio_q, d_prio_d;

    // Whoever was granted last yields on the next contention.
    always_comb begin
        d_prio_d = d_prio_q;
        if (gnt_i) begin
            d_prio_d = 1'b1;
        end else if (gnt_d) begin
            d_prio_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            d_prio_q <= 1'b1;
        end else begin
            d_prio_q <= d_prio_d;
        end
    end

    assign d_wins = d_prio_q | ~i_req;
`else
    assign d_wins = 1'b1;
`endif

    // MMU request mux; the address holds its last granted value between grants.
    always_comb begin
        mem_addr    = addr_q;
        mem_wr_ena  = 1'b0;
        mem_wr_data = '0;
        if (gnt_i) begin
            mem_addr = i_addr;
        end else if (gnt_d) begin
            mem_addr    = d_addr;
            mem_wr_ena  = d_wr_ena;
            mem_wr_data = d_wr_data;
        end
    end

    assign addr_d = mem_addr;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    // Response pipeline: state register
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= ST_NONE;
        end else begin
            state_q <= state_d;
        end
    end

    // Response pipeline: next state is purely the type of the access accepted this cycle
    always_comb begin
        state_d = ST_NONE;
        if (gnt_i) begin
            state_d = ST_RD_I;
        end else if (gnt_d) begin
            state_d = d_wr_ena ? ST_WR_D : ST_RD_D;
        end
    end

    // Response pipeline: outputs; writes complete at grant and produce no response
    always_comb begin
        i_rvalid = 1'b0;
        d_rvalid = 1'b0;
        i_rdata  = '0;
        d_rdata  = '0;
        case (state_q)
            ST_RD_I: begin
                i_rvalid = 1'b1;
                i_rdata  = mem_rd_data;
            end
            ST_RD_D: begin
                d_rvalid = 1'b1;
                d_rdata  = mem_rd_data;
            end
            default: begin
                i_rvalid = 1'b0;
                d_rvalid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mmu_bus_arbiter.sv
// Directed bench for mmu_bus_arbiter with a transaction-level model checked every cycle.
module tb_mmu_bus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rstb;
    logic          i_req, d_req, d_wr_ena, mem_busy;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic [DW-1:0] d_wr_data, mem_wr_data, mem_rd_data, i_rdata, d_rdata;
    logic          i_gnt, i_rvalid, d_gnt, d_rvalid, mem_wr_ena;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mmu_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rstb(rstb),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_wr_ena(d_wr_ena), .d_wr_data(d_wr_data),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wr_ena(mem_wr_ena), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data), .mem_busy(mem_busy)
    );

    // Memory contents as a pure function of address; data returns one cycle after the address.
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return a ^ 32'hA5A5_0000;
    endfunction

    always @(posedge clk) mem_rd_data <= mem_val(mem_addr);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model: who wins, what was last addressed, what answer is owed ----------------
    logic        m_d_first;
    logic [31:0] m_last_addr;
    logic        m_rsp_vld, m_rsp_d;
    logic [31:0] m_rsp_addr;
    logic [1:0]  m_pick;

    // returns {d_granted, i_granted}
    function automatic logic [1:0] pick(input logic ir, input logic dr, input logic busy,
                                        input logic d_first);
        if (busy) return 2'b00;
        if (ir && dr) return d_first ? 2'b10 : 2'b01;
        if (dr) return 2'b10;
        if (ir) return 2'b01;
        return 2'b00;
    endfunction

    assign m_pick = pick(i_req, d_req, mem_busy, m_d_first);

    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            m_d_first   <= 1'b1;
            m_last_addr <= '0;
            m_rsp_vld   <= 1'b0;
            m_rsp_d     <= 1'b0;
            m_rsp_addr  <= '0;
        end else begin
`ifdef MMU_ARB_ROUND_ROBIN_EN
            if (m_pick[1]) m_d_first <= 1'b0;
            else if (m_pick[0]) m_d_first <= 1'b1;
`endif
            if (m_pick[1]) m_last_addr <= d_addr;
            else if (m_pick[0]) m_last_addr <= i_addr;
            m_rsp_vld  <= m_pick[0] | (m_pick[1] & ~d_wr_ena);
            m_rsp_d    <= m_pick[1];
            m_rsp_addr <= m_pick[1] ? d_addr : i_addr;
        end
    end

    // ---------------- per-cycle comparison against the model ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            if (!rstb) begin
                chk("rst_i_gnt", i_gnt, 0);
                chk("rst_d_gnt", d_gnt, 0);
                chk("rst_i_rvalid", i_rvalid, 0);
                chk("rst_d_rvalid", d_rvalid, 0);
                chk("rst_i_rdata", i_rdata, 0);
                chk("rst_d_rdata", d_rdata, 0);
                chk("rst_mem_addr", mem_addr, 0);
                chk("rst_mem_wr_ena", mem_wr_ena, 0);
                chk("rst_mem_wr_data", mem_wr_data, 0);
            end else begin
                chk("m_i_gnt", i_gnt, m_pick[0]);
                chk("m_d_gnt", d_gnt, m_pick[1]);
                chk("m_mem_addr", mem_addr,
                    m_pick[1] ? d_addr : (m_pick[0] ? i_addr : m_last_addr));
                chk("m_mem_wr_ena", mem_wr_ena, m_pick[1] & d_wr_ena);
                if (m_pick != 2'b00)
                    chk("m_mem_wr_data", mem_wr_data, m_pick[1] ? d_wr_data : 32'h0);
                chk("m_i_rvalid", i_rvalid, m_rsp_vld & ~m_rsp_d);
                chk("m_d_rvalid", d_rvalid, m_rsp_vld & m_rsp_d);
                chk("m_i_rdata", i_rdata, (m_rsp_vld & ~m_rsp_d) ? mem_val(m_rsp_addr) : 32'h0);
                chk("m_d_rdata", d_rdata, (m_rsp_vld & m_rsp_d) ? mem_val(m_rsp_addr) : 32'h0);
            end
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req = 0; d_req = 0; d_wr_ena = 0; mem_busy = 0;
        i_addr = '0; d_addr = '0; d_wr_data = '0;
    endtask

    task automatic do_reset();
        step();
        rstb = 0;
        idle_inputs();
        step();
        step();
        rstb = 1;
    endtask

    initial begin
        logic        exp_d;
        logic        busy;
        logic [31:0] a;
        logic [4:0]  kv;

        rstb = 0;
        idle_inputs();
        step();
        chk_en = 1'b1;
        step();
        step();
        rstb = 1;

        // single instruction read
        i_req = 1; i_addr = 32'h100;
        #3;
        chk("ird_i_gnt", i_gnt, 1);
        chk("ird_d_gnt", d_gnt, 0);
        chk("ird_mem_addr", mem_addr, 32'h100);
        step();
        i_req = 0;
        #3;
        chk("ird_i_rvalid", i_rvalid, 1);
        chk("ird_i_rdata", i_rdata, 32'hDEADBEEF);
        chk("ird_d_rvalid", d_rvalid, 0);
        step();

        // single data write
        d_req = 1; d_addr = 32'h200; d_wr_ena = 1; d_wr_data = 32'h12345678;
        #3;
        chk("dwr_d_gnt", d_gnt, 1);
        chk("dwr_mem_wr_ena", mem_wr_ena, 1);
        chk("dwr_mem_addr", mem_addr, 32'h200);
        chk("dwr_mem_wr_data", mem_wr_data, 32'h12345678);
        step();
        d_req = 0; d_wr_ena = 0; d_wr_data = '0;
        #3;
        chk("dwr_gnt_drop", d_gnt, 0);
        chk("dwr_no_rvalid", d_rvalid, 0);
        chk("dwr_wr_ena_drop", mem_wr_ena, 0);
        chk("dwr_addr_hold", mem_addr, 32'h200);

        // contention for 6 cycles from fresh reset
        do_reset();
        i_req = 1; d_req = 1; i_addr = 32'h500; d_addr = 32'h600;
        for (int k = 0; k < 6; k++) begin
`ifdef MMU_ARB_ROUND_ROBIN_EN
            exp_d = (k % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            #3;
            chk("cont_d_gnt", d_gnt, exp_d);
            chk("cont_i_gnt", i_gnt, !exp_d);
            step();
        end
        idle_inputs();
        step();

        // busy window in cycles 2-4 of an instruction stream
        a = 32'h300;
        for (int c = 0; c < 8; c++) begin
            busy = (c >= 2 && c <= 4);
            i_req = 1; i_addr = a; mem_busy = busy;
            #3;
            chk("busy_i_gnt", i_gnt, !busy);
            if (c == 2) begin
                chk("busy_rvalid_c2", i_rvalid, 1);
                chk("busy_rdata_c2", i_rdata, 32'hA5A50304);
            end
            if (c == 3) chk("busy_rvalid_c3", i_rvalid, 0);
            step();
            if (!busy) a = a + 4;
        end
        idle_inputs();
        step();

        // reset in the cycle after a data read grant
        d_req = 1; d_addr = 32'h400;
        #3;
        chk("rstmid_d_gnt", d_gnt, 1);
        step();
        rstb = 0; i_req = 1;
        #3;
        chk("rstmid_i_gnt", i_gnt, 0);
        chk("rstmid_d_gnt0", d_gnt, 0);
        chk("rstmid_d_rvalid", d_rvalid, 0);
        chk("rstmid_d_rdata", d_rdata, 0);
        chk("rstmid_mem_addr", mem_addr, 0);
        step();
        #3;
        chk("rstmid_d_rvalid_b", d_rvalid, 0);
        step();
        rstb = 1;
        idle_inputs();
        #3;
        chk("rstrel_d_rvalid", d_rvalid, 0);
        step();
        #3;
        chk("rstrel_d_rvalid_b", d_rvalid, 0);
        step();

        // enumerated mix: requests, writes, withdrawals and busy cycles
        for (int k = 0; k < 32; k++) begin
            kv = 5'(k);
            i_req     = kv[0];
            d_req     = kv[1];
            d_wr_ena  = kv[2];
            mem_busy  = (kv[4:3] == 2'b11);
            i_addr    = 32'h1000 + 32'(k) * 4;
            d_addr    = 32'h2000 + 32'(k) * 8;
            d_wr_data = 32'(k) * 32'h01010101;
            step();
        end
        idle_inputs();
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
